// File: rtl/fetch_unit_pkg.sv
// Shared constants and the queued-entry type for the instruction fetch stage.
package fetch_unit_pkg;

   localparam int unsigned WORD_WIDTH  = 32;
   localparam int unsigned INST_BYTES  = 4;
   localparam int unsigned FETCH_DEPTH = 2;
   localparam logic [WORD_WIDTH-1:0] PC_ALIGN_MASK = 32'hFFFF_FFFC;

   typedef struct packed {
      logic [WORD_WIDTH-1:0] pc;
      logic [WORD_WIDTH-1:0] word;
   } fetch_entry_t;

   function automatic logic [WORD_WIDTH-1:0] align_pc(input logic [WORD_WIDTH-1:0] pc);
      return pc & PC_ALIGN_MASK;
   endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, word} fetch entries; flush beats push and pop.
module fetch_fifo
   import fetch_unit_pkg::*;
#(
   parameter int unsigned WIDTH = 2 * WORD_WIDTH,
   parameter int unsigned DEPTH = FETCH_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push_i,
   input  logic                     pop_i,
   input  logic                     flush_i,
   input  logic [WIDTH-1:0]         data_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_q, wr_d;
   logic [AW-1:0]    rd_q, rd_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign do_push = push_i & ~full_o;
   assign do_pop  = pop_i & ~empty_o;

   // Empty queue presents zero rather than stale storage.
   assign data_o  = empty_o ? '0 : mem_q[rd_q];

   always_comb begin
      wr_d    = wr_q;
      rd_d    = rd_q;
      count_d = count_q;
      if (flush_i) begin
         wr_d    = '0;
         rd_d    = '0;
         count_d = '0;
      end else begin
         if (do_push) wr_d = wr_q + AW'(1);
         if (do_pop)  rd_d = rd_q + AW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush_i) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC, one in-flight memory read, credit-based issue and an entry queue.
module fetch_unit
   import fetch_unit_pkg::*;
#(
   parameter logic [WORD_WIDTH-1:0] RESET_PC = '0,
   parameter int unsigned           DEPTH    = FETCH_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   output logic [WORD_WIDTH-1:0] ir_addr,
   input  logic [WORD_WIDTH-1:0] ir_data,
   input  logic                  redirect_valid,
   input  logic [WORD_WIDTH-1:0] redirect_pc,
   input  logic                  dec_ready,
   output logic                  inst_valid,
   output logic [WORD_WIDTH-1:0] inst_data,
   output logic [WORD_WIDTH-1:0] inst_pc
);

   localparam int unsigned CRW = $clog2(DEPTH) + 2;

   logic [WORD_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [WORD_WIDTH-1:0] inflight_pc_q, inflight_pc_d;
   logic                  inflight_q, inflight_d;

   logic                  fifo_full, fifo_empty;
   logic [$clog2(DEPTH):0] fifo_count;
   fetch_entry_t          push_entry, head_entry;
   logic                  pop, push, issue;
   logic [CRW-1:0]        credit;

   assign pop    = ~fifo_empty & dec_ready;
   // Occupancy after this cycle: queued + outstanding read - accepted head.
   assign credit = CRW'(fifo_count) + CRW'(inflight_q) - CRW'(pop);
   assign issue  = ~redirect_valid & (credit < CRW'(DEPTH));
   assign push   = inflight_q & ~redirect_valid & ~fifo_full;

   assign push_entry.pc   = inflight_pc_q;
   assign push_entry.word = ir_data;

   always_comb begin
      fetch_pc_d    = fetch_pc_q;
      inflight_pc_d = inflight_pc_q;
      inflight_d    = issue;
      if (redirect_valid) begin
         fetch_pc_d = align_pc(redirect_pc);
      end else if (issue) begin
         inflight_pc_d = fetch_pc_q;
         fetch_pc_d    = fetch_pc_q + WORD_WIDTH'(INST_BYTES);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         inflight_pc_q <= '0;
         inflight_q    <= 1'b0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         inflight_pc_q <= inflight_pc_d;
         inflight_q    <= inflight_d;
      end
   end

   fetch_fifo #(
      .WIDTH ($bits(fetch_entry_t)),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (redirect_valid),
      .data_i  (push_entry),
      .data_o  (head_entry),
      .full_o  (fifo_full),
      .empty_o (fifo_empty),
      .count_o (fifo_count)
   );

   assign ir_addr    = fetch_pc_q;
   assign inst_valid = ~fifo_empty;
   assign inst_data  = head_entry.word;
   assign inst_pc    = head_entry.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, backpressure, redirects, PC wrap, mid-stream reset.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] ir_addr, ir_data;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        dec_ready = 1'b0;
   logic        inst_valid;
   logic [31:0] inst_data, inst_pc;

   logic [31:0] w_ir_addr, w_ir_data;
   logic        w_inst_valid;
   logic [31:0] w_inst_data, w_inst_pc;

   int unsigned errors = 0;
   int unsigned checks = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk            (clk),
      .rst            (rst),
      .ir_addr        (ir_addr),
      .ir_data        (ir_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .dec_ready      (dec_ready),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .DEPTH(2)) dut_wrap (
      .clk            (clk),
      .rst            (rst),
      .ir_addr        (w_ir_addr),
      .ir_data        (w_ir_data),
      .redirect_valid (1'b0),
      .redirect_pc    (32'h0),
      .dec_ready      (1'b1),
      .inst_valid     (w_inst_valid),
      .inst_data      (w_inst_data),
      .inst_pc        (w_inst_pc)
   );

   // Memory image: word at address a is a ^ 0x5A5A0000.
   function automatic logic [31:0] word_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   always @(posedge clk) begin
      ir_data   <= word_of(ir_addr);
      w_ir_data <= word_of(w_ir_addr);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic expect_head(input string tag, input logic v, input logic [31:0] pc);
      check({tag, "_valid"}, 32'(inst_valid), 32'(v));
      check({tag, "_pc"},    inst_pc,   v ? pc : 32'h0);
      check({tag, "_data"},  inst_data, v ? word_of(pc) : 32'h0);
   endtask

   task automatic next_cycle;
      @(posedge clk);
      @(negedge clk);
   endtask

   // Leaves the caller at the sampling point of cycle 0.
   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc = '0;
      #1;
      expect_head("rst", 1'b0, 32'h0);
      check("rst_addr", ir_addr, 32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1);
   end

   initial begin
      // Reset then streaming, plus wrap instance
      do_reset();
      dec_ready = 1'b1;
      check("s1_c0_addr", ir_addr, 32'h0);
      expect_head("s1_c0", 1'b0, 32'h0);
      next_cycle();
      expect_head("s1_c1", 1'b0, 32'h0);
      next_cycle();
      expect_head("s1_c2", 1'b1, 32'h0000_0000);
      check("wrap_c2_pc",   w_inst_pc,   32'hFFFF_FFFC);
      check("wrap_c2_data", w_inst_data, 32'hA5A5_FFFC);
      next_cycle();
      expect_head("s1_c3", 1'b1, 32'h0000_0004);
      check("wrap_c3_pc",   w_inst_pc,   32'h0000_0000);
      check("wrap_c3_data", w_inst_data, 32'h5A5A_0000);
      for (int i = 4; i < 8; i++) begin
         next_cycle();
         expect_head($sformatf("s1_c%0d", i), 1'b1, 32'(4 * (i - 2)));
      end

      // Backpressure from cycle 2 for 5 cycles
      do_reset();
      dec_ready = 1'b1;
      next_cycle();
      next_cycle();
      expect_head("bp_c2", 1'b1, 32'h0);
      dec_ready = 1'b0;
      for (int i = 3; i < 7; i++) begin
         next_cycle();
         expect_head($sformatf("bp_c%0d", i), 1'b1, 32'h0);
         check($sformatf("bp_c%0d_addr", i), ir_addr, 32'h8);
      end
      next_cycle();
      expect_head("bp_c7", 1'b1, 32'h0);
      dec_ready = 1'b1;
      next_cycle();
      expect_head("bp_c8", 1'b1, 32'h4);
      check("bp_c8_addr", ir_addr, 32'hC);
      next_cycle();
      expect_head("bp_c9", 1'b1, 32'h8);
      next_cycle();
      expect_head("bp_c10", 1'b1, 32'hC);

      // Redirect while streaming (target 0x43 -> 0x40)
      redirect_valid = 1'b1;
      redirect_pc = 32'h43;
      next_cycle();
      redirect_valid = 1'b0;
      expect_head("rd_t1", 1'b0, 32'h0);
      check("rd_t1_addr", ir_addr, 32'h40);
      next_cycle();
      expect_head("rd_t2", 1'b0, 32'h0);
      next_cycle();
      expect_head("rd_t3", 1'b1, 32'h40);
      next_cycle();
      expect_head("rd_t4", 1'b1, 32'h44);
      next_cycle();
      expect_head("rd_t5", 1'b1, 32'h48);

      // Redirect with a queued word and a read in flight
      do_reset();
      dec_ready = 1'b0;
      next_cycle();
      next_cycle();
      expect_head("rf_c2", 1'b1, 32'h0);
      redirect_valid = 1'b1;
      redirect_pc = 32'h80;
      next_cycle();
      redirect_valid = 1'b0;
      expect_head("rf_c3", 1'b0, 32'h0);
      check("rf_c3_addr", ir_addr, 32'h80);
      next_cycle();
      expect_head("rf_c4", 1'b0, 32'h0);
      next_cycle();
      expect_head("rf_c5", 1'b1, 32'h80);
      dec_ready = 1'b1;
      next_cycle();
      expect_head("rf_c6", 1'b1, 32'h84);
      next_cycle();
      expect_head("rf_c7", 1'b1, 32'h88);
      dec_ready = 1'b0;
      next_cycle();
      expect_head("rf_c8", 1'b1, 32'h88);
      check("rf_c8_addr", ir_addr, 32'h90);

      // Redirect while queue is full (low bits of target ignored)
      redirect_valid = 1'b1;
      redirect_pc = 32'h102;
      next_cycle();
      redirect_valid = 1'b0;
      expect_head("rq_c9", 1'b0, 32'h0);
      check("rq_c9_addr", ir_addr, 32'h100);
      next_cycle();
      expect_head("rq_c10", 1'b0, 32'h0);
      next_cycle();
      expect_head("rq_c11", 1'b1, 32'h100);
      dec_ready = 1'b1;
      next_cycle();
      expect_head("rq_c12", 1'b1, 32'h104);

      // Mid-stream half-cycle reset pulse with a full queue
      do_reset();
      dec_ready = 1'b1;
      next_cycle();
      next_cycle();
      expect_head("mr_c2", 1'b1, 32'h0);
      dec_ready = 1'b0;
      next_cycle();
      expect_head("mr_c3", 1'b1, 32'h0);
      @(posedge clk);
      #1 rst = 1'b1;
      #1;
      expect_head("mr_pulse", 1'b0, 32'h0);
      check("mr_pulse_addr", ir_addr, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      dec_ready = 1'b1;
      expect_head("mr_r0", 1'b0, 32'h0);
      next_cycle();
      expect_head("mr_r1", 1'b0, 32'h0);
      next_cycle();
      expect_head("mr_r2", 1'b1, 32'h0);
      next_cycle();
      expect_head("mr_r3", 1'b1, 32'h4);
      next_cycle();
      expect_head("mr_r4", 1'b1, 32'h8);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
